// File: rtl/bmem_pkg.sv
// Shared constants, types and beat helpers for the banked burst memory port.
package bmem_pkg;

  localparam int unsigned BURST_LEN = 4;
  localparam int unsigned BEAT_W    = 64;
  localparam int unsigned LINE_W    = 256;
  localparam int unsigned LINE_OFS  = 5;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned OUTST_W   = 3;

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((32'd1 << LINE_OFS) - 32'd1);

  typedef enum logic {IDLE, WBURST} bmem_wr_state_t;
  typedef logic [255:0] line_t;
  typedef logic [BEAT_W-1:0] beat_t;

  // Extract beat k of a line (beat k = bits [64k+63:64k]).
  function automatic beat_t line_beat(input line_t l, input logic [CNT_W-1:0] k);
    return l[{k, 6'b0} +: BEAT_W];
  endfunction

  // Return a copy of a line with beat k replaced.
  function automatic line_t line_put(input line_t l, input logic [CNT_W-1:0] k,
                                     input beat_t b);
    line_t r;
    r = l;
    r[{k, 6'b0} +: BEAT_W] = b;
    return r;
  endfunction

  // Align an address down to its cache line.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
    return a & LINE_MASK;
  endfunction

endpackage

// File: rtl/bmem_burst_assembler.sv
// Collects 4-beat return bursts into a line, latches the burst tag and flags protocol errors.
module bmem_burst_assembler
  import bmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rvalid,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [BEAT_W-1:0] rdata,
  input  logic              outst_zero,
  output logic              done_c,
  output line_t             line_c,
  output logic [ADDR_W-1:0] tag,
  output logic              err
);

  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  line_t             buf_q, buf_d;
  logic              err_q, err_d;

  // Beat slotting, tag capture, completion strobe and sticky error detection.
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    tag_d      = tag_q;
    buf_d      = buf_q;
    err_d      = err_q;
    done_c     = 1'b0;
    if (rvalid) begin
      buf_d      = line_put(buf_q, beat_cnt_q, rdata);
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
      if (beat_cnt_q == '0) begin
        tag_d = raddr;
        if (outst_zero) err_d = 1'b1;
      end else if (raddr != tag_q) begin
        err_d = 1'b1;
      end
      if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) done_c = 1'b1;
    end else if (beat_cnt_q != '0) begin
      err_d = 1'b1;
    end
    line_c = buf_d;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
      tag_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      tag_q      <= tag_d;
      err_q      <= err_d;
    end
  end

  // Assembly buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  assign tag = tag_q;
  assign err = err_q;

endmodule

// File: rtl/bmem_line_adapter.sv
// Cache-line to 4-beat burst adapter: issues reads/writes and reassembles returned lines.
module bmem_line_adapter
  import bmem_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] up_addr,
  input  logic              up_read,
  input  logic              up_write,
  input  line_t             up_wdata,
  output logic              up_ready,
  output logic              up_rvalid,
  output logic [ADDR_W-1:0] up_raddr,
  output line_t             up_rdata,
  output logic              err,
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [BEAT_W-1:0] bmem_wdata,
  input  logic              bmem_ready,
  input  logic [ADDR_W-1:0] bmem_raddr,
  input  logic [BEAT_W-1:0] bmem_rdata,
  input  logic              bmem_rvalid
);

  bmem_wr_state_t    state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  line_t             wline_q, wline_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [OUTST_W-1:0] outst_q, outst_d;
  logic              up_rvalid_q, up_rvalid_d;
  logic [ADDR_W-1:0] up_raddr_q, up_raddr_d;
  line_t             up_rdata_q, up_rdata_d;

  logic              rd_acc;
  logic              done_c;
  line_t             line_c;
  logic [ADDR_W-1:0] tag;

  bmem_burst_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .rvalid     (bmem_rvalid),
    .raddr      (bmem_raddr),
    .rdata      (bmem_rdata),
    .outst_zero (outst_q == '0),
    .done_c     (done_c),
    .line_c     (line_c),
    .tag        (tag),
    .err        (err)
  );

  // Issue FSM next state, combinational command outputs and outstanding-read accounting.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    wline_d     = wline_q;
    waddr_d     = waddr_q;
    outst_d     = outst_q;
    up_ready    = 1'b0;
    bmem_read   = 1'b0;
    bmem_write  = 1'b0;
    bmem_addr   = '0;
    bmem_wdata  = '0;
    rd_acc      = 1'b0;

    if (state_q == IDLE) begin
      up_ready = bmem_ready &&
                 (up_write || (outst_q < OUTST_W'(MAX_OUTSTANDING)));
      if (up_ready && up_read) begin
        bmem_read = 1'b1;
        bmem_addr = line_addr(up_addr);
        rd_acc    = 1'b1;
      end else if (up_ready && up_write) begin
        bmem_write = 1'b1;
        bmem_addr  = line_addr(up_addr);
        bmem_wdata = line_beat(up_wdata, '0);
        wline_d    = up_wdata;
        waddr_d    = line_addr(up_addr);
        wcnt_d     = CNT_W'(1);
        state_d    = WBURST;
      end
    end else begin
      // Beats 1..3 go out back to back; the memory is committed once beat 0 is taken.
      bmem_write = 1'b1;
      bmem_addr  = waddr_q;
      bmem_wdata = line_beat(wline_q, wcnt_q);
      wcnt_d     = wcnt_q + CNT_W'(1);
      if (wcnt_q == CNT_W'(BURST_LEN - 1)) state_d = IDLE;
    end

    if (rd_acc && !done_c) begin
      outst_d = outst_q + OUTST_W'(1);
    end else if (!rd_acc && done_c && (outst_q != '0)) begin
      outst_d = outst_q - OUTST_W'(1);
    end

    up_rvalid_d = done_c;
    up_raddr_d  = done_c ? tag    : up_raddr_q;
    up_rdata_d  = done_c ? line_c : up_rdata_q;

    // Nothing leaves the block while reset is held.
    if (rst) begin
      up_ready   = 1'b0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_addr  = '0;
      bmem_wdata = '0;
    end
  end

  // State registers with synchronous reset; the write line buffer is not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      waddr_q     <= '0;
      outst_q     <= '0;
      up_rvalid_q <= 1'b0;
      up_raddr_q  <= '0;
      up_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      waddr_q     <= waddr_d;
      outst_q     <= outst_d;
      up_rvalid_q <= up_rvalid_d;
      up_raddr_q  <= up_raddr_d;
      up_rdata_q  <= up_rdata_d;
    end
  end

  // Write line holding register.
  always_ff @(posedge clk) begin
    wline_q <= wline_d;
  end

  assign up_rvalid = up_rvalid_q;
  assign up_raddr  = up_raddr_q;
  assign up_rdata  = up_rdata_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed bench for bmem_line_adapter with a scoreboard of expected returned lines.
module tb_bmem_line_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  up_addr;
  logic         up_read;
  logic         up_write;
  logic [255:0] up_wdata;
  logic         up_ready;
  logic         up_rvalid;
  logic [31:0]  up_raddr;
  logic [255:0] up_rdata;
  logic         err;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  typedef struct {
    logic [31:0]  a;
    logic [255:0] d;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  bmem_line_adapter #(.MAX_OUTSTANDING(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .up_addr     (up_addr),
    .up_read     (up_read),
    .up_write    (up_write),
    .up_wdata    (up_wdata),
    .up_ready    (up_ready),
    .up_rvalid   (up_rvalid),
    .up_raddr    (up_raddr),
    .up_rdata    (up_rdata),
    .err         (err),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk_line(input logic [7:0] seed);
    logic [255:0] l;
    for (int k = 0; k < 4; k++) l[64*k +: 64] = {8{seed + 8'(k)}};
    return l;
  endfunction

  function automatic logic [63:0] beat(input logic [255:0] l, input int k);
    return l[64*k +: 64];
  endfunction

  // Scoreboard: every returned line must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && up_rvalid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_rvalid", 256'(up_raddr), 256'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_raddr", 256'(up_raddr), 256'(e.a));
        chk("sb_rdata", up_rdata, e.d);
      end
    end
  end

  // Watchdog keeps the run bounded.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] l1, lw, la, lb, lr, lw2;
    logic [31:0]  ooo_addr [2];
    logic [255:0] ooo_line [2];

    rst = 1'b1; up_addr = '0; up_read = 1'b0; up_write = 1'b0; up_wdata = '0;
    bmem_ready = 1'b1; bmem_raddr = '0; bmem_rdata = '0; bmem_rvalid = 1'b0;

    // Reset values
    tick(); tick();
    chk("rst_up_ready", 256'(up_ready), 256'(0));
    chk("rst_up_rvalid", 256'(up_rvalid), 256'(0));
    chk("rst_err", 256'(err), 256'(0));
    chk("rst_bmem_read", 256'(bmem_read), 256'(0));
    chk("rst_bmem_write", 256'(bmem_write), 256'(0));
    chk("rst_bmem_addr", 256'(bmem_addr), 256'(0));
    chk("rst_bmem_wdata", 256'(bmem_wdata), 256'(0));
    chk("rst_up_raddr", 256'(up_raddr), 256'(0));
    chk("rst_up_rdata", up_rdata, 256'(0));
    rst = 1'b0;

    // Single read with low address bits ignored
    up_read = 1'b1; up_addr = 32'h0000_105F;
    #1;
    chk("rd_up_ready", 256'(up_ready), 256'(1));
    chk("rd_bmem_read", 256'(bmem_read), 256'(1));
    chk("rd_bmem_addr", 256'(bmem_addr), 256'(32'h0000_1040));
    tick();
    up_read = 1'b0;
    #1;
    chk("rd_bmem_read_drop", 256'(bmem_read), 256'(0));
    l1 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
          64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    sb.push_back('{a: 32'h0000_1040, d: l1});
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_1040; bmem_rdata = beat(l1, k);
      tick();
      chk("rd_rvalid_timing", 256'(up_rvalid), 256'(k == 3));
    end
    bmem_rvalid = 1'b0;
    chk("rd_up_raddr", 256'(up_raddr), 256'(32'h0000_1040));
    chk("rd_up_rdata", up_rdata, l1);
    tick();
    chk("rd_rvalid_pulse_end", 256'(up_rvalid), 256'(0));
    chk("rd_err", 256'(err), 256'(0));

    // Write burst, up_write held through WBURST
    lw = {64'hDDDD_0000_0000_DDDD, 64'hCCCC_0000_0000_CCCC,
          64'hBBBB_0000_0000_BBBB, 64'hAAAA_0000_0000_AAAA};
    up_write = 1'b1; up_addr = 32'h0000_2000; up_wdata = lw;
    #1;
    chk("wr_up_ready0", 256'(up_ready), 256'(1));
    chk("wr_bmem_write0", 256'(bmem_write), 256'(1));
    chk("wr_bmem_addr0", 256'(bmem_addr), 256'(32'h0000_2000));
    chk("wr_bmem_wdata0", 256'(bmem_wdata), 256'(beat(lw, 0)));
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("wr_up_ready_busy", 256'(up_ready), 256'(0));
      chk("wr_bmem_write", 256'(bmem_write), 256'(1));
      chk("wr_bmem_addr", 256'(bmem_addr), 256'(32'h0000_2000));
      chk("wr_bmem_wdata", 256'(bmem_wdata), 256'(beat(lw, k)));
    end
    up_write = 1'b0;
    tick();
    chk("wr_done_bmem_write", 256'(bmem_write), 256'(0));
    chk("wr_done_up_ready", 256'(up_ready), 256'(1));

    // Outstanding limit: third read stalls until the first line completes
    up_read = 1'b1; up_addr = 32'h0000_0100;
    tick();
    up_addr = 32'h0000_0200;
    tick();
    up_addr = 32'h0000_0300;
    #1;
    chk("lim_stall_ready", 256'(up_ready), 256'(0));
    chk("lim_stall_read", 256'(bmem_read), 256'(0));
    la = mk_line(8'h50);
    sb.push_back('{a: 32'h0000_0100, d: la});
    for (int k = 0; k < 4; k++) begin
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0100; bmem_rdata = beat(la, k);
      #1;
      chk("lim_stall_during_return", 256'(up_ready), 256'(0));
      tick();
    end
    bmem_rvalid = 1'b0;
    #1;
    chk("lim_release_ready", 256'(up_ready), 256'(1));
    chk("lim_release_read", 256'(bmem_read), 256'(1));
    chk("lim_release_addr", 256'(bmem_addr), 256'(32'h0000_0300));
    chk("lim_line_rvalid", 256'(up_rvalid), 256'(1));
    tick();
    up_read = 1'b0;

    // Out-of-order, back-to-back return: 0x300 first, then 0x200
    ooo_addr[0] = 32'h0000_0300; ooo_line[0] = mk_line(8'h70);
    ooo_addr[1] = 32'h0000_0200; ooo_line[1] = mk_line(8'h90);
    sb.push_back('{a: ooo_addr[0], d: ooo_line[0]});
    sb.push_back('{a: ooo_addr[1], d: ooo_line[1]});
    for (int b = 0; b < 2; b++) begin
      for (int k = 0; k < 4; k++) begin
        bmem_rvalid = 1'b1; bmem_raddr = ooo_addr[b]; bmem_rdata = beat(ooo_line[b], k);
        tick();
        chk("ooo_rvalid_timing", 256'(up_rvalid), 256'(k == 3));
        if (k == 3) chk("ooo_raddr", 256'(up_raddr), 256'(ooo_addr[b]));
      end
    end
    bmem_rvalid = 1'b0;
    chk("ooo_err", 256'(err), 256'(0));
    tick();

    // Write issued while a read is returning
    up_read = 1'b1; up_addr = 32'h0000_0400;
    tick();
    up_read = 1'b0;
    lw2 = mk_line(8'hA0);
    lr  = mk_line(8'hC0);
    sb.push_back('{a: 32'h0000_0400, d: lr});
    for (int k = 0; k < 4; k++) begin
      up_write = (k == 0); up_addr = 32'h0000_0500; up_wdata = lw2;
      bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0400; bmem_rdata = beat(lr, k);
      #1;
      chk("par_bmem_write", 256'(bmem_write), 256'(1));
      chk("par_bmem_wdata", 256'(bmem_wdata), 256'(beat(lw2, k)));
      tick();
    end
    bmem_rvalid = 1'b0; up_write = 1'b0;
    chk("par_up_rvalid", 256'(up_rvalid), 256'(1));
    chk("par_up_raddr", 256'(up_raddr), 256'(32'h0000_0400));
    #1;
    chk("par_write_done", 256'(bmem_write), 256'(0));
    tick();

    // Tag change within a burst raises err
    up_read = 1'b1; up_addr = 32'h0000_0700;
    tick();
    up_read = 1'b0;
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0700; bmem_rdata = 64'h1;
    tick();
    chk("tag_no_err_yet", 256'(err), 256'(0));
    bmem_raddr = 32'h0000_0740;
    tick();
    bmem_rvalid = 1'b0;
    chk("tag_change_err", 256'(err), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("tag_rst_err_clear", 256'(err), 256'(0));

    // Unsolicited beat with nothing outstanding; err is sticky
    bmem_rvalid = 1'b1; bmem_raddr = 32'h0000_0800; bmem_rdata = 64'h2;
    tick();
    bmem_rvalid = 1'b0;
    chk("unsol_err", 256'(err), 256'(1));
    tick(); tick();
    chk("unsol_err_sticky", 256'(err), 256'(1));

    // Reset in the middle of a write burst
    up_write = 1'b1; up_addr = 32'h0000_0600; up_wdata = lw;
    tick();
    up_write = 1'b0;
    tick();
    chk("mid_wr_active", 256'(bmem_write), 256'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_wr_rst_write", 256'(bmem_write), 256'(0));
    chk("mid_wr_rst_err", 256'(err), 256'(0));
    chk("mid_wr_rst_ready", 256'(up_ready), 256'(1));
    bmem_ready = 1'b0;
    #1;
    chk("mid_wr_rst_ready_follow", 256'(up_ready), 256'(0));
    tick(); tick();
    chk("mid_wr_no_resume", 256'(bmem_write), 256'(0));
    chk("sb_drained", 256'(sb.size()), 256'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
